decode_ctrl_stage: RTL

- Parametrised successor to the combinational main decoder: full RV32I control decode plus the registered D→E pipeline boundary, in one block.
- Decodes InstrD in D and produces ImmSrcD combinationally for the in-stage extender.
- Registers all execute-stage control into E behind a valid/ready handshake, with flush, illegal-instruction detection, a saturating illegal counter and an optional halt-on-illegal state machine.

---
 rtl/decode_ctrl_if.sv | 52 +++++
 rtl/decode_ctrl_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_if.sv
// ---------------------------------------------------------------------------
// decode_ctrl_if -- signal bundle between the decode stage, its upstream
// instruction source and the execute stage that consumes its E register.
//
//   D side : InstrD, ValidD (to block), ReadyD, ImmSrcD (from block)
//   flow   : FlushE, ReadyE (to block)
//   E side : ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUSrcAE, ALUSrcE,
//            ALUControlE, BranchE, JumpE, JalrE, Funct3E, RdE, IllegalE
//   status : IllegalCount, Halted
//
// modport master : the surrounding pipeline (drives InstrD/ValidD/FlushE/ReadyE)
// modport slave  : decode_ctrl_stage
// ---------------------------------------------------------------------------
interface decode_ctrl_if #(
  parameter int ILL_CNT_W = 8
);
  logic [31:0]          InstrD;
  logic                 ValidD;
  logic                 ReadyD;
  logic                 FlushE;
  logic                 ReadyE;
  logic [2:0]           ImmSrcD;
  logic                 ValidE;
  logic                 RegWriteE;
  logic [1:0]           ResultSrcE;
  logic                 MemWriteE;
  logic                 ALUSrcAE;
  logic                 ALUSrcE;
  logic [3:0]           ALUControlE;
  logic                 BranchE;
  logic                 JumpE;
  logic                 JalrE;
  logic [2:0]           Funct3E;
  logic [4:0]           RdE;
  logic                 IllegalE;
  logic [ILL_CNT_W-1:0] IllegalCount;
  logic                 Halted;

  modport master (
    output InstrD, ValidD, FlushE, ReadyE,
    input  ReadyD, ImmSrcD, ValidE, RegWriteE, ResultSrcE, MemWriteE,
           ALUSrcAE, ALUSrcE, ALUControlE, BranchE, JumpE, JalrE,
           Funct3E, RdE, IllegalE, IllegalCount, Halted
  );

  modport slave (
    input  InstrD, ValidD, FlushE, ReadyE,
    output ReadyD, ImmSrcD, ValidE, RegWriteE, ResultSrcE, MemWriteE,
           ALUSrcAE, ALUSrcE, ALUControlE, BranchE, JumpE, JalrE,
           Funct3E, RdE, IllegalE, IllegalCount, Halted
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage -- RV32I control decode plus the registered D->E boundary.
//
// InstrD is decoded in D; ImmSrcD goes straight to the in-stage immediate
// extender. Execute-stage control is captured into the E register when the
// block accepts an instruction (ValidD && ReadyD). Illegal encodings are
// flagged, have their side-effecting controls suppressed and are counted
// (saturating). With ILL_HALT=1 the block stops accepting after the first
// accepted illegal instruction until reset.
//
// Ports: clk, rst_n (async, active-low) and bus (decode_ctrl_if.slave).
// Parameters:
//   ILL_CNT_W : width of IllegalCount (must match the interface instance)
//   ILL_HALT  : 1 = enter HALT after accepting an illegal instruction
// Build option:
//   M_EXT_EN  : when defined, decode mul/mulh/mulhsu/mulhu (funct7=0000001,
//               funct3 000-011); otherwise every funct7=0000001 is illegal.
// ---------------------------------------------------------------------------
module decode_ctrl_stage #(
  parameter int ILL_CNT_W = 8,
  parameter int ILL_HALT  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASSB  = 4'b1010,
    ALU_MUL    = 4'b1011,
    ALU_MULH   = 4'b1100,
    ALU_MULHSU = 4'b1101,
    ALU_MULHU  = 4'b1110
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_U = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src_a;
    logic       alu_src;
    alu_op_e    alu_ctrl;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Shared funct3 -> ALU op map for R-type and OP-IMM; alt selects sub/sra.
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs_fields;

  assign opcode           = bus.InstrD[6:0];
  assign funct3           = bus.InstrD[14:12];
  assign funct7           = bus.InstrD[31:25];
  assign unused_rs_fields = ^bus.InstrD[24:15];

  ctrl_t    dec;
  imm_src_e imm_src_d;

  // -------------------------------------------------------------------------
  // D-stage decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned (which would infer a latch).
    dec       = '0;
    imm_src_d = IMM_I;

    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.alu_ctrl = alu_base(funct3, funct7[5]);
        end else if (funct7 == 7'b0000001) begin
`ifdef M_EXT_EN
          case (funct3)
            3'b000:  dec.alu_ctrl = ALU_MUL;
            3'b001:  dec.alu_ctrl = ALU_MULH;
            3'b010:  dec.alu_ctrl = ALU_MULHSU;
            3'b011:  dec.alu_ctrl = ALU_MULHU;
            default: dec.illegal  = 1'b1;  // div/rem not provided
          endcase
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end

      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
          dec.illegal = 1'b1;
        end else if (funct3 == 3'b101 && funct7 != 7'b0000000 &&
                     funct7 != 7'b0100000) begin
          dec.illegal = 1'b1;
        end else begin
          // Only the right-shift form uses funct7[5]; addi must never become sub.
          dec.alu_ctrl = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end

      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end

      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src_d     = IMM_S;
        dec.illegal   = (funct3 > 3'b010);
      end

      OP_BR: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        imm_src_d    = IMM_B;
        dec.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
        imm_src_d     = IMM_U;
      end

      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src_d     = IMM_U;
      end

      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        imm_src_d      = IMM_J;
      end

      OP_JALR: begin
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_src    = 1'b1;
        dec.illegal    = (funct3 != 3'b000);
      end

      default: dec.illegal = 1'b1;
    endcase

    // An illegal instruction must not change architectural state.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  assign bus.ImmSrcD = imm_src_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  state_e state_q;
  logic   halted_q;
  logic   valid_q;
  logic   ready_d;
  logic   accept;

  // A flush in the same cycle blocks acceptance, so a flushed-over
  // instruction is neither consumed nor counted.
  assign ready_d    = (state_q == ST_RUN) && !bus.FlushE && (!valid_q || bus.ReadyE);
  assign accept     = bus.ValidD && ready_d;
  assign bus.ReadyD = ready_d;

  // -------------------------------------------------------------------------
  // D->E register
  // -------------------------------------------------------------------------
  ctrl_t      ctrl_q;
  logic [2:0] funct3_q;
  logic [4:0] rd_q;

  // NOTE: the whole E register is reset, not just ValidE, because the
  // execute stage and observers see all control outputs as 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
    end else if (bus.FlushE) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      valid_q  <= 1'b1;
      ctrl_q   <= dec;
      funct3_q <= bus.InstrD[14:12];
      rd_q     <= bus.InstrD[11:7];
    end else if (valid_q && bus.ReadyE) begin
      valid_q  <= 1'b0;  // consumed; control fields hold
    end
  end

  assign bus.ValidE      = valid_q;
  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.ALUSrcAE    = ctrl_q.alu_src_a;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ALUControlE = ctrl_q.alu_ctrl;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.JalrE       = ctrl_q.jalr;
  assign bus.IllegalE    = ctrl_q.illegal;
  assign bus.Funct3E     = funct3_q;
  assign bus.RdE         = rd_q;

  // -------------------------------------------------------------------------
  // Illegal counter and RUN/HALT state machine
  // -------------------------------------------------------------------------
  logic [ILL_CNT_W-1:0] ill_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_q <= '0;
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
    end else if (accept && dec.illegal) begin
      if (ill_cnt_q != '1) begin
        ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
      end
      if (ILL_HALT != 0) begin
        state_q  <= ST_HALT;  // only reset leaves HALT
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.IllegalCount = ill_cnt_q;
  assign bus.Halted       = halted_q;

endmodule
